dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (`ram` instance, DATA_W x 2^ADDR_W words) between two requesters:
  - the CPU MEM stage;
  - a loader/debug port used to preload or inspect data memory.
- Issues at most one memory access per cycle.
- Stalls the CPU when the CPU loses arbitration.
- Returns read data to the requester that issued the read, one cycle later.
- Sits between the MEM stage and `data_memory`. The MEM stage drives word addresses, i.e. byte address bits [5:2].

Parameters:
- DATA_W, 32, data width of memory and both ports.
- ADDR_W, 4, word-address width (16 words).
- MAX_WAIT, 3, consecutive cycles the loader may be refused before it is forced a grant.
- MAX_BURST, 4, max consecutive loader beats while cpu_req is high.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  cpu_req & ~cpu_gnt (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  DATA_W  CPU read data
- ldr_req  in  1  loader access request
- ldr_we  in  1  loader write enable
- ldr_addr  in  ADDR_W  loader word address
- ldr_wdata  in  DATA_W  loader write data
- ldr_gnt  out  1  loader access issued this cycle (combinational)
- ldr_rvalid  out  1  loader read data valid (registered)
- ldr_rdata  out  DATA_W  loader read data
- mem_write  out  1  to ram write enable
- mem_read  out  1  to ram read enable
- mem_addr  out  ADDR_W  to ram address
- mem_wdata  out  DATA_W  to ram write data
- mem_rdata  in  DATA_W  from ram; valid one cycle after mem_read

Behaviour:
- Reset (reset==0 at rising edge):
  - state=S_CPU; wait_cnt=0; burst_cnt=0; rd_owner=NONE.
  - cpu_rvalid=0, ldr_rvalid=0, cpu_rdata=0, ldr_rdata=0.
  - Combinational outputs while reset is low: mem_read=mem_write=0, ldr_gnt=0, cpu_stall=cpu_req.
  - Reset mid-burst or mid-read discards any pending rvalid. No access is issued during the reset cycle.
- Grant per cycle (combinational from state, counters, requests):
  - S_CPU: CPU granted if cpu_req and not (ldr_req && wait_cnt==MAX_WAIT). Otherwise the loader is granted if ldr_req.
  - S_LDR: loader granted if ldr_req and (!cpu_req || burst_cnt<MAX_BURST). Otherwise the CPU is granted if cpu_req.
  - Neither request: no grant; mem_read=mem_write=0.
- Memory drive:
  - The granted requester's addr/wdata pass to mem_addr/mem_wdata.
  - mem_write = gnt & we; mem_read = gnt & ~we.
  - Ungranted: mem_addr and mem_wdata hold 0.
- State transitions (at clock edge):
  - Loader granted → S_LDR.
  - CPU granted, or idle → S_CPU.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when ldr_req is high and the loader is not granted.
  - Clears on loader grant or when ldr_req is low.
- burst_cnt:
  - Increments (saturating) on a loader grant while cpu_req is high.
  - Clears when the CPU is granted or the state returns to S_CPU.
- Reads:
  - A read granted in cycle T records rd_owner.
  - In T+1 that owner's rvalid=1 and rdata=mem_rdata (registered capture at end of T+1). The other requester's rvalid=0 and its rdata holds its previous value.
  - Back-to-back reads from alternating owners are legal; rd_owner updates every cycle.
- Writes: complete at the edge ending the grant cycle; no rvalid.
- Read-after-write to the same address from either port in consecutive cycles returns the new data.
- Starvation bounds:
  - The CPU waits at most MAX_BURST cycles.
  - The loader waits at most MAX_WAIT+1 cycles.

Decomposition:
- Shared package `dmem_arb_pkg`:
  - state encoding S_CPU/S_LDR;
  - owner encoding NONE/CPU/LDR;
  - default MAX_WAIT and MAX_BURST constants.
- One natural sub-module: `dmem_rd_return`. It holds the rd_owner register and the rvalid/rdata steering registers.
- Arbitration FSM and counters stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with cpu_req=1 → mem_read=mem_write=0, cpu_stall=1, both rvalid=0, both rdata=0.
- CPU only:
  - write addr 3 data 0xDEADBEEF, then read addr 3 → no stall.
  - cpu_rvalid=1 with cpu_rdata=0xDEADBEEF exactly one cycle after the read grant.
- Loader starvation:
  - cpu_req and ldr_req held high continuously → CPU granted 3 cycles, cpu_stall=0.
  - Loader forced on 4th cycle: ldr_gnt=1, cpu_stall=1.
- Loader burst:
  - loader writes addrs 0..7 with cpu_req held high from beat 0 → at most 4 consecutive ldr_gnt.
  - Then CPU granted one cycle; cpu_stall never high more than 4 consecutive cycles.
- Alternating reads:
  - CPU reads addr 1 (0x11) in T, loader reads addr 2 (0x22) in T+1.
  - → cpu_rvalid/0x11 in T+1, ldr_rvalid/0x22 in T+2, never both valid.
- Reset mid-read:
  - loader read granted in T, reset=0 in T+1 → ldr_rvalid stays 0.
  - State S_CPU after reset is released.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter slice.
//   - arb_state_t : which requester currently holds arbitration priority
//   - rd_owner_t  : which requester issued the read whose data returns next
//   - default starvation/burst bounds and a counter-width helper
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_LDR = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } rd_owner_t;

    localparam int DEF_MAX_WAIT  = 32'sd3;
    localparam int DEF_MAX_BURST = 32'sd4;

    // Bits needed for a counter that saturates at max_val (never less than 1).
    function automatic int cnt_w(input int max_val);
        int w;
        if (max_val < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = $clog2(max_val + 32'sd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_rd_return.sv
// dmem_rd_return: steers the single ram read-data bus back to the port that
// issued the read. The issuing port is recorded when the read is granted; in
// the following cycle that port sees rvalid with the live ram data, and the
// data is also captured so the port's rdata holds it afterwards.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   cpu_rd_issue      : CPU read granted this cycle
//   ldr_rd_issue      : loader read granted this cycle
//   mem_rdata         : ram read data (valid the cycle after the read)
//   cpu_rvalid/rdata  : CPU read return
//   ldr_rvalid/rdata  : loader read return
import dmem_arb_pkg::*;

module dmem_rd_return #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd_issue,
    input  logic              ldr_rd_issue,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata
);

    rd_owner_t         rd_owner_r;
    logic [DATA_W-1:0] cpu_hold_r;
    logic [DATA_W-1:0] ldr_hold_r;

    // Record the read owner each cycle and capture returned data for holding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_owner_r <= OWN_NONE;
            cpu_hold_r <= {DATA_W{1'b0}};
            ldr_hold_r <= {DATA_W{1'b0}};
        end else begin
            if (cpu_rd_issue) begin
                rd_owner_r <= OWN_CPU;
            end else if (ldr_rd_issue) begin
                rd_owner_r <= OWN_LDR;
            end else begin
                rd_owner_r <= OWN_NONE;
            end

            if (rd_owner_r == OWN_CPU) begin
                cpu_hold_r <= mem_rdata;
            end else begin
                cpu_hold_r <= cpu_hold_r;
            end

            if (rd_owner_r == OWN_LDR) begin
                ldr_hold_r <= mem_rdata;
            end else begin
                ldr_hold_r <= ldr_hold_r;
            end
        end
    end

    // rvalid is suppressed while reset is low so a read in flight is dropped.
    always_comb begin
        cpu_rvalid = reset && (rd_owner_r == OWN_CPU);
        ldr_rvalid = reset && (rd_owner_r == OWN_LDR);
        if (cpu_rvalid) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = cpu_hold_r;
        end
        if (ldr_rvalid) begin
            ldr_rdata = mem_rdata;
        end else begin
            ldr_rdata = ldr_hold_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data ram between the CPU MEM stage and
// a loader/debug port. One access per cycle; the CPU is stalled when it loses.
// The loader is forced in after MAX_WAIT refusals, and a loader burst is cut
// after MAX_BURST beats while the CPU is waiting.
// Ports:
//   clk, reset                       : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata            : CPU request
//   cpu_stall                        : CPU requested but was not granted
//   cpu_rvalid/cpu_rdata             : CPU read return (one cycle after grant)
//   ldr_req/we/addr/wdata            : loader request
//   ldr_gnt                          : loader access issued this cycle
//   ldr_rvalid/ldr_rdata             : loader read return
//   mem_write/read/addr/wdata        : ram command
//   mem_rdata                        : ram read data, one cycle after mem_read
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W  = cnt_w(MAX_WAIT);
    localparam int BURST_W = cnt_w(MAX_BURST);
    localparam logic [WAIT_W-1:0]  WAIT_MAX_C  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(MAX_BURST);
    localparam logic [WAIT_W-1:0]  WAIT_ONE_C  = WAIT_W'(32'd1);
    localparam logic [BURST_W-1:0] BURST_ONE_C = BURST_W'(32'd1);

    arb_state_t         state_r;
    arb_state_t         state_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_nxt_s;
    logic [BURST_W-1:0] burst_cnt_r;
    logic [BURST_W-1:0] burst_cnt_nxt_s;
    logic               cpu_gnt_s;
    logic               ldr_gnt_s;

    // Grant decision; nothing is granted while reset is low.
    always_comb begin
        cpu_gnt_s = 1'b0;
        ldr_gnt_s = 1'b0;
        if (reset) begin
            case (state_r)
                S_CPU: begin
                    if (cpu_req && !(ldr_req && (wait_cnt_r == WAIT_MAX_C))) begin
                        cpu_gnt_s = 1'b1;
                    end else if (ldr_req) begin
                        ldr_gnt_s = 1'b1;
                    end else begin
                        cpu_gnt_s = 1'b0;
                    end
                end
                S_LDR: begin
                    if (ldr_req && (!cpu_req || (burst_cnt_r < BURST_MAX_C))) begin
                        ldr_gnt_s = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        ldr_gnt_s = 1'b0;
                    end
                end
                default: begin
                    cpu_gnt_s = cpu_req;
                end
            endcase
        end else begin
            cpu_gnt_s = 1'b0;
        end
    end

    // Next state and starvation/burst counters.
    always_comb begin
        if (ldr_gnt_s) begin
            state_nxt_s = S_LDR;
        end else begin
            state_nxt_s = S_CPU;
        end

        if (!ldr_req || ldr_gnt_s) begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else if (wait_cnt_r < WAIT_MAX_C) begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE_C;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end

        // Only loader beats taken while the CPU waits count toward the burst.
        if (cpu_gnt_s || (state_nxt_s == S_CPU)) begin
            burst_cnt_nxt_s = {BURST_W{1'b0}};
        end else if (cpu_req && (burst_cnt_r < BURST_MAX_C)) begin
            burst_cnt_nxt_s = burst_cnt_r + BURST_ONE_C;
        end else begin
            burst_cnt_nxt_s = burst_cnt_r;
        end
    end

    // Arbitration state and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= S_CPU;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            burst_cnt_r <= {BURST_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Drive the ram from the granted requester; idle bus is all zero.
    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (cpu_gnt_s) begin
            mem_write = cpu_we;
            mem_read  = ~cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ldr_gnt_s) begin
            mem_write = ldr_we;
            mem_read  = ~ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end else begin
            mem_write = 1'b0;
        end
    end

    // Handshake outputs.
    always_comb begin
        cpu_stall = cpu_req & ~cpu_gnt_s;
        ldr_gnt   = ldr_gnt_s;
    end

    dmem_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk          (clk),
        .reset        (reset),
        .cpu_rd_issue (cpu_gnt_s & ~cpu_we),
        .ldr_rd_issue (ldr_gnt_s & ~ldr_we),
        .mem_rdata    (mem_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .ldr_rvalid   (ldr_rvalid),
        .ldr_rdata    (ldr_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural single-port ram
// (registered read, one cycle latency) attached to the mem_* bus.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ldr_req;
    logic        ldr_we;
    logic [3:0]  ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram_q [16];

    int checks;
    int errors;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram: write at the edge, registered read data.
    always @(posedge clk) begin
        if (mem_write) ram_q[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= ram_q[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [13:0] pat;
        int          beat;
        int          run;
        checks    = 0;
        errors    = 0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 16; i++) ram_q[i] = 32'h0;
        reset     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 4'd3;
        cpu_wdata = 32'h0;
        ldr_req   = 1'b0;
        ldr_we    = 1'b0;
        ldr_addr  = 4'd0;
        ldr_wdata = 32'h0;

        // Reset held two cycles with a CPU request pending.
        @(negedge clk);
        chk("rst1_mem_read",  {31'd0, mem_read},  32'd0);
        chk("rst1_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst1_stall",     {31'd0, cpu_stall}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("rst2_mem_read",  {31'd0, mem_read},   32'd0);
        chk("rst2_stall",     {31'd0, cpu_stall},  32'd1);
        chk("rst2_ldr_gnt",   {31'd0, ldr_gnt},    32'd0);
        chk("rst2_cpu_rvalid",{31'd0, cpu_rvalid}, 32'd0);
        chk("rst2_ldr_rvalid",{31'd0, ldr_rvalid}, 32'd0);
        chk("rst2_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst2_ldr_rdata", ldr_rdata, 32'h0);
        next_cycle();

        // CPU only: write then read addr 3.
        reset     = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 4'd3;
        cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("cpu_wr_stall",  {31'd0, cpu_stall}, 32'd0);
        chk("cpu_wr_mwrite", {31'd0, mem_write}, 32'd1);
        chk("cpu_wr_maddr",  {28'd0, mem_addr},  32'd3);
        chk("cpu_wr_mwdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("cpu_rd_stall",  {31'd0, cpu_stall},  32'd0);
        chk("cpu_rd_mread",  {31'd0, mem_read},   32'd1);
        chk("cpu_rd_rvalid0",{31'd0, cpu_rvalid}, 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_rd_rvalid1",{31'd0, cpu_rvalid}, 32'd1);
        chk("cpu_rd_rdata",  cpu_rdata, 32'hDEADBEEF);
        chk("idle_maddr",    {28'd0, mem_addr}, 32'd0);
        chk("idle_mread",    {31'd0, mem_read}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("cpu_rvalid_drop",{31'd0, cpu_rvalid}, 32'd0);
        chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        next_cycle();

        // Contention: CPU reads addr 3, loader writes addr*0x11 to addrs 0..7.
        // Expected grant sequence: C C C L L L L C C C L L L L (bit set = loader).
        pat  = 14'b11110001111000;
        beat = 0;
        run  = 0;
        for (int c = 0; c < 14; c++) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'b0;
            cpu_addr  = 4'd3;
            ldr_req   = 1'b1;
            ldr_we    = 1'b1;
            ldr_addr  = beat[3:0];
            ldr_wdata = beat * 32'h11;
            @(negedge clk);
            chk($sformatf("arb_ldr_gnt_c%0d", c), {31'd0, ldr_gnt},   {31'd0, pat[c]});
            chk($sformatf("arb_stall_c%0d", c),   {31'd0, cpu_stall}, {31'd0, pat[c]});
            if (pat[c]) begin
                chk($sformatf("arb_maddr_c%0d", c), {28'd0, mem_addr}, beat);
                chk($sformatf("arb_mwrite_c%0d", c), {31'd0, mem_write}, 32'd1);
            end
            if (cpu_stall) run++;
            else           run = 0;
            chk($sformatf("stall_run_le4_c%0d", c), {31'd0, (run <= 4)}, 32'd1);
            if (ldr_gnt) beat++;
            next_cycle();
        end
        chk("ldr_beats_done", beat, 32'd8);

        // Idle one cycle so the arbiter returns to CPU priority.
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge clk);
        chk("idle_ldr_gnt", {31'd0, ldr_gnt}, 32'd0);
        next_cycle();

        // Alternating reads: CPU addr 1 then loader addr 2.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 4'd1;
        @(negedge clk);
        chk("alt_cpu_mread", {31'd0, mem_read},  32'd1);
        chk("alt_cpu_maddr", {28'd0, mem_addr},  32'd1);
        chk("alt_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        next_cycle();
        cpu_req  = 1'b0;
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 4'd2;
        @(negedge clk);
        chk("alt_ldr_gnt",      {31'd0, ldr_gnt},    32'd1);
        chk("alt_cpu_rvalid",   {31'd0, cpu_rvalid}, 32'd1);
        chk("alt_cpu_rdata",    cpu_rdata, 32'h11);
        chk("alt_ldr_rvalid0",  {31'd0, ldr_rvalid}, 32'd0);
        next_cycle();
        ldr_req = 1'b0;
        @(negedge clk);
        chk("alt_ldr_rvalid",   {31'd0, ldr_rvalid}, 32'd1);
        chk("alt_ldr_rdata",    ldr_rdata, 32'h22);
        chk("alt_cpu_rvalid0",  {31'd0, cpu_rvalid}, 32'd0);
        chk("alt_cpu_rdata_hold", cpu_rdata, 32'h11);
        next_cycle();

        // Reset mid-read: loader read addr 5 granted, reset in the next cycle.
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 4'd5;
        @(negedge clk);
        chk("mr_ldr_gnt", {31'd0, ldr_gnt},  32'd1);
        chk("mr_mread",   {31'd0, mem_read}, 32'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mr_ldr_rvalid_rst", {31'd0, ldr_rvalid}, 32'd0);
        chk("mr_ldr_gnt_rst",    {31'd0, ldr_gnt},    32'd0);
        chk("mr_mread_rst",      {31'd0, mem_read},   32'd0);
        next_cycle();
        reset    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 4'd3;
        @(negedge clk);
        chk("mr_ldr_rvalid_post", {31'd0, ldr_rvalid}, 32'd0);
        chk("mr_ldr_rdata_post",  ldr_rdata, 32'h0);
        chk("mr_state_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("mr_state_cpu_lgnt",  {31'd0, ldr_gnt},   32'd0);
        next_cycle();
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
